// File: rtl/vga_console_writer_pkg.sv
// Shared definitions for the VGA console writer: control codes, RAM address
// field layout, FSM state encoding and small address/counter helpers.
package vga_console_writer_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam int PLANE_BIT = 12;
    localparam int ROW_LSB   = 6;
    localparam int COL_LSB   = 0;

    localparam logic [7:0] DEFAULT_ATTR_INIT = 8'hF0;

    typedef enum logic [2:0] {
        IDLE,
        PUT_CH,
        PUT_AT,
        CLR_LN_CH,
        CLR_LN_AT,
        CLR_SCR_CH,
        CLR_SCR_AT
    } state_t;

    // Build a RAM address: plane 0 holds characters, plane 1 holds colours.
    function automatic logic [12:0] ram_addr(input logic plane,
                                             input logic [5:0] row,
                                             input logic [5:0] col);
        logic [12:0] a;
        a = '0;
        a[PLANE_BIT]     = plane;
        a[ROW_LSB +: 6]  = row;
        a[COL_LSB +: 6]  = col;
        return a;
    endfunction

    // Increment that wraps at an explicit last value instead of 6-bit overflow.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v,
                                            input logic [5:0] last);
        return (v == last) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/vga_console_clear_seq.sv
// Cell sweep counter used by both row clear and full-screen clear.
// col/row name the cell being cleared now; next_col/next_row name the cell
// that follows, and done flags the final cell of the sweep.
module vga_console_clear_seq
    import vga_console_writer_pkg::*;
#(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter bit RESET_FULL = 1'b1
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       start_full,
    input  logic [5:0] start_row,
    input  logic       step,
    output logic [5:0] col,
    output logic [5:0] row,
    output logic [5:0] next_col,
    output logic [5:0] next_row,
    output logic       done
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    logic full_q;

    // Successor cell: columns first, rows only advance in full-screen mode.
    always_comb begin
        next_col = col + 6'd1;
        next_row = row;
        done     = 1'b0;
        if (col == LAST_COL) begin
            next_col = 6'd0;
            if (full_q) begin
                next_row = wrap_inc(row, LAST_ROW);
            end
            done = !full_q || (row == LAST_ROW);
        end
    end

    // Sweep position register; start takes priority over step.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            col    <= 6'd0;
            row    <= 6'd0;
            full_q <= RESET_FULL;
        end else if (start) begin
            col    <= 6'd0;
            row    <= start_full ? 6'd0 : start_row;
            full_q <= start_full;
        end else if (step) begin
            col    <= next_col;
            row    <= next_row;
        end
    end

endmodule

// File: rtl/vga_console_writer.sv
// Terminal engine feeding the write side of the VGA text-mode RAM: accepts a
// byte stream, tracks the cursor and issues one registered write per cycle.
module vga_console_writer
    import vga_console_writer_pkg::*;
#(
    parameter int         COLS           = 40,
    parameter int         ROWS           = 30,
    parameter logic [7:0] DEFAULT_ATTR   = DEFAULT_ATTR_INIT,
    parameter int         CLEAR_ON_RESET = 1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_attr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic [5:0]  cur_col,
    output logic [5:0]  cur_row,
    output logic        busy
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    state_t      state_q, state_n;
    logic [7:0]  attr_q, attr_n;
    logic [5:0]  col_n, row_n;
    logic        wr_en_n;
    logic [12:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic        accept;

    logic        seq_start, seq_full, seq_step, seq_done;
    logic [5:0]  seq_row_start;
    logic [5:0]  seq_col, seq_row, seq_next_col, seq_next_row;

    assign in_ready = (state_q == IDLE) && !reset;
    assign busy     = !in_ready;
    assign accept   = in_valid && in_ready;

    vga_console_clear_seq #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .RESET_FULL (CLEAR_ON_RESET != 0)
    ) u_clear_seq (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .start      (seq_start),
        .start_full (seq_full),
        .start_row  (seq_row_start),
        .step       (seq_step),
        .col        (seq_col),
        .row        (seq_row),
        .next_col   (seq_next_col),
        .next_row   (seq_next_row),
        .done       (seq_done)
    );

    // Next state plus the write that will be visible during that next state.
    always_comb begin
        state_n       = state_q;
        attr_n        = attr_q;
        col_n         = cur_col;
        row_n         = cur_row;
        wr_en_n       = 1'b0;
        wr_addr_n     = wr_addr;
        wr_data_n     = wr_data;
        seq_start     = 1'b0;
        seq_full      = 1'b0;
        seq_row_start = 6'd0;
        seq_step      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    attr_n = in_attr;
                    case (in_data)
                        CH_CR: col_n = 6'd0;
                        CH_BS: begin
                            if (cur_col != 6'd0) col_n = cur_col - 6'd1;
                        end
                        CH_LF: begin
                            col_n         = 6'd0;
                            row_n         = wrap_inc(cur_row, LAST_ROW);
                            seq_start     = 1'b1;
                            seq_row_start = row_n;
                            state_n       = CLR_LN_CH;
                            wr_en_n       = 1'b1;
                            wr_addr_n     = ram_addr(1'b0, row_n, 6'd0);
                            wr_data_n     = CH_SPACE;
                        end
                        CH_FF: begin
                            col_n     = 6'd0;
                            row_n     = 6'd0;
                            seq_start = 1'b1;
                            seq_full  = 1'b1;
                            state_n   = CLR_SCR_CH;
                            wr_en_n   = 1'b1;
                            wr_addr_n = ram_addr(1'b0, 6'd0, 6'd0);
                            wr_data_n = CH_SPACE;
                        end
                        default: begin
                            if ((in_data >= 8'h20) && (in_data != CH_DEL)) begin
                                state_n   = PUT_CH;
                                wr_en_n   = 1'b1;
                                wr_addr_n = ram_addr(1'b0, cur_row, cur_col);
                                wr_data_n = in_data;
                            end
                        end
                    endcase
                end
            end
            PUT_CH: begin
                state_n   = PUT_AT;
                wr_en_n   = 1'b1;
                wr_addr_n = ram_addr(1'b1, cur_row, cur_col);
                wr_data_n = attr_q;
            end
            PUT_AT: begin
                if (cur_col != LAST_COL) begin
                    col_n   = cur_col + 6'd1;
                    state_n = IDLE;
                end else begin
                    col_n         = 6'd0;
                    row_n         = wrap_inc(cur_row, LAST_ROW);
                    seq_start     = 1'b1;
                    seq_row_start = row_n;
                    state_n       = CLR_LN_CH;
                    wr_en_n       = 1'b1;
                    wr_addr_n     = ram_addr(1'b0, row_n, 6'd0);
                    wr_data_n     = CH_SPACE;
                end
            end
            CLR_LN_CH, CLR_SCR_CH: begin
                // wr_en is only low here straight after reset: issue the first
                // character write before moving on to its colour write.
                if (!wr_en) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = ram_addr(1'b0, seq_row, seq_col);
                    wr_data_n = CH_SPACE;
                end else begin
                    state_n   = (state_q == CLR_LN_CH) ? CLR_LN_AT : CLR_SCR_AT;
                    wr_en_n   = 1'b1;
                    wr_addr_n = ram_addr(1'b1, seq_row, seq_col);
                    wr_data_n = attr_q;
                end
            end
            CLR_LN_AT, CLR_SCR_AT: begin
                if (seq_done) begin
                    state_n = IDLE;
                end else begin
                    seq_step  = 1'b1;
                    state_n   = (state_q == CLR_LN_AT) ? CLR_LN_CH : CLR_SCR_CH;
                    wr_en_n   = 1'b1;
                    wr_addr_n = ram_addr(1'b0, seq_next_row, seq_next_col);
                    wr_data_n = CH_SPACE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, cursor, attribute and registered write port.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLR_SCR_CH : IDLE;
            attr_q  <= DEFAULT_ATTR;
            cur_col <= 6'd0;
            cur_row <= 6'd0;
            wr_en   <= 1'b0;
            wr_addr <= 13'd0;
            wr_data <= 8'd0;
        end else begin
            state_q <= state_n;
            attr_q  <= attr_n;
            cur_col <= col_n;
            cur_row <= row_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

endmodule
